// File: rtl/acorn_decrypt_process_pkg.sv
// ACORN-128 shared definitions: widths, tap positions,
// step schedule, FSM encoding and boolean helpers.
package acorn_decrypt_process_pkg;

    localparam int STATE_W   = 293;
    localparam int MSG_BITS  = 128;
    localparam int PAD_STEPS = 256;
    localparam int CNT_W     = 9;

    localparam int T0   = 0;
    localparam int T12  = 12;
    localparam int T23  = 23;
    localparam int T61  = 61;
    localparam int T66  = 66;
    localparam int T107 = 107;
    localparam int T111 = 111;
    localparam int T154 = 154;
    localparam int T160 = 160;
    localparam int T193 = 193;
    localparam int T196 = 196;
    localparam int T230 = 230;
    localparam int T235 = 235;
    localparam int T244 = 244;
    localparam int T289 = 289;

    // last message step, pad-bit step, first ca=0 step, last step
    localparam logic [CNT_W-1:0] LAST_DEC = 9'd127;
    localparam logic [CNT_W-1:0] PAD_ONE  = 9'd128;
    localparam logic [CNT_W-1:0] CA_END   = 9'd256;
    localparam logic [CNT_W-1:0] LAST_PAD = 9'd383;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_PAD  = 2'd2
    } fsm_e;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

endpackage

// File: rtl/acorn_decrypt_process_if.sv
// Request/result bundle of the ACORN ciphertext processor.
// master drives start and operands; slave returns results.
interface acorn_decrypt_process_if;
    import acorn_decrypt_process_pkg::*;

    logic                start;
    logic [STATE_W-1:0]  state_in;
    logic [MSG_BITS-1:0] ct_in;
    logic [MSG_BITS-1:0] pt_out;
    logic [STATE_W-1:0]  state_out;
    logic                busy;
    logic                done;

    modport master (
        output start, state_in, ct_in,
        input  pt_out, state_out, busy, done
    );

    modport slave (
        input  start, state_in, ct_in,
        output pt_out, state_out, busy, done
    );

endinterface

// File: rtl/acorn_step.sv
// One ACORN-128 state-update step, purely combinational.
// Shared by the encrypt, decrypt and finalization datapaths.
module acorn_step
    import acorn_decrypt_process_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic               ca,
    input  logic               cb,
    input  logic               m_sel,
    input  logic               ct_bit,
    output logic               ks,
    output logic               m,
    output logic [STATE_W-1:0] state_o
);

    logic [STATE_W-1:0] s;
    logic               f;

    // LFSR feedback, keystream, message bit and shifted next state
    always_comb begin
        s       = state_i;
        s[T289] = state_i[T289] ^ state_i[T235] ^ state_i[T230];
        s[T230] = state_i[T230] ^ state_i[T196] ^ state_i[T193];
        s[T193] = state_i[T193] ^ state_i[T160] ^ state_i[T154];
        s[T154] = state_i[T154] ^ state_i[T111] ^ state_i[T107];
        s[T107] = state_i[T107] ^ state_i[T66]  ^ state_i[T61];
        s[T61]  = state_i[T61]  ^ state_i[T23]  ^ state_i[T0];

        ks = s[T12] ^ s[T154]
           ^ maj(s[T235], s[T61], s[T193])
           ^ ch(s[T230], s[T111], s[T66]);

        m = m_sel ? (ct_bit ^ ks) : ct_bit;

        f = s[T0] ^ ~s[T107]
          ^ maj(s[T244], s[T23], s[T160])
          ^ (ca & s[T196]) ^ (cb & ks) ^ m;

        state_o = {f, s[STATE_W-1:1]};
    end

endmodule

// File: rtl/acorn_decrypt_process.sv
// Bit-serial ACORN-128 decryption: 128 message steps then
// 256 padding steps, one step per clock.
module acorn_decrypt_process
    import acorn_decrypt_process_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    acorn_decrypt_process_if.slave bus
);

    fsm_e                fsm_q, fsm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [MSG_BITS-1:0] ct_q, ct_d;
    logic [MSG_BITS-1:0] pt_q, pt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                step_ca;
    logic                step_msel;
    logic                step_in;
    logic                step_ks;
    logic                step_m;
    logic [STATE_W-1:0]  step_next;

    // step controls: pad bit is a literal 1 only at step 128
    always_comb begin
        step_ca   = (cnt_q < CA_END);
        step_msel = (fsm_q == ST_DEC);
        step_in   = step_msel ? ct_q[cnt_q[6:0]]
                              : (cnt_q == PAD_ONE);
    end

    acorn_step u_step (
        .state_i (state_q),
        .ca      (step_ca),
        .cb      (1'b0),
        .m_sel   (step_msel),
        .ct_bit  (step_in),
        .ks      (step_ks),
        .m       (step_m),
        .state_o (step_next)
    );

    // sequencing: accept, decrypt, pad, then report
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        ct_d    = ct_q;
        pt_d    = pt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (bus.start) begin
                    fsm_d   = ST_DEC;
                    state_d = bus.state_in;
                    ct_d    = bus.ct_in;
                    pt_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_DEC: begin
                state_d             = step_next;
                pt_d[cnt_q[6:0]]    = step_m;
                cnt_d               = cnt_q + 9'd1;
                if (cnt_q == LAST_DEC) begin
                    fsm_d = ST_PAD;
                end
            end
            ST_PAD: begin
                state_d = step_next;
                if (cnt_q == LAST_PAD) begin
                    fsm_d  = ST_IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                fsm_d  = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    // state registers, reset dominates everything
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            ct_q    <= '0;
            pt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ct_q    <= ct_d;
            pt_q    <= pt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pt_out    = pt_q;
    assign bus.state_out = state_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    logic unused_ks;
    assign unused_ks = step_ks;

endmodule
